// File: rtl/riscv_config_pkg.sv
// Core-wide configuration constants shared by the execute-stage units.
package riscv_config_pkg;

  // Architectural register width (32 for RV32, 64 for RV64).
  localparam int unsigned XLEN = 32;

  // Default cycles from multiply issue to result; legal range 1..8.
  localparam int unsigned DEFAULT_MULT_LATENCY = 3;

endpackage

// File: rtl/riscv_core_pkg.sv
// Shared types for the multiply unit: operation encoding, tag width, request bundle
// and small decode helpers for operand extension and result half selection.
package riscv_core_pkg;

  import riscv_config_pkg::*;

  localparam int unsigned MULT_TAG_WIDTH = 4;

  // Low two bits of funct3 for the RV M-extension multiplies.
  typedef enum logic [1:0] {
    OpMul    = 2'b00,
    OpMulh   = 2'b01,
    OpMulhsu = 2'b10,
    OpMulhu  = 2'b11
  } mult_op_e;

  typedef struct packed {
    mult_op_e                  op;
    logic [XLEN-1:0]           a;
    logic [XLEN-1:0]           b;
    logic [MULT_TAG_WIDTH-1:0] tag;
  } mult_req_t;

  // rs1 is treated as signed for everything except MULHU.
  function automatic logic op_a_signed(mult_op_e op);
    return op != OpMulhu;
  endfunction

  // rs2 is treated as signed only for MUL and MULH.
  function automatic logic op_b_signed(mult_op_e op);
    return (op == OpMul) || (op == OpMulh);
  endfunction

  // Every op except MUL returns the upper half of the product.
  function automatic logic op_high_half(mult_op_e op);
    return op != OpMul;
  endfunction

endpackage

// File: rtl/mult_pipe_core.sv
// Signed (W+1)x(W+1) multiplier with a LATENCY-deep valid/data pipeline.
// Stage 1 registers the extended operands; the multiplier sits behind them and the
// remaining LATENCY-1 stages register the product so synthesis can retime into the
// multiplier. With LATENCY=1 the product is combinational from stage 1.
// A side bus carries per-operation metadata alongside the data.
module mult_pipe_core #(
  parameter int unsigned W          = 32,
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned SIDE_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush,
  input  logic                  advance,
  input  logic                  in_valid,
  input  logic [W:0]            a,
  input  logic [W:0]            b,
  input  logic [SIDE_WIDTH-1:0] side_in,
  output logic                  out_valid,
  output logic [2*W-1:0]        prod,
  output logic [SIDE_WIDTH-1:0] side_out,
  output logic                  busy
);

  logic                  s1_valid;
  logic [W:0]            s1_a;
  logic [W:0]            s1_b;
  logic [SIDE_WIDTH-1:0] s1_side;

  // Stage 1: capture operands; flush kills the valid bit even while stalled.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_side  <= '0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (advance) begin
        s1_valid <= in_valid;
      end
      if (advance) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_side <= side_in;
      end
    end
  end

  logic signed [2*W+1:0] a_wide;
  logic signed [2*W+1:0] b_wide;
  logic signed [2*W+1:0] prod_full;
  logic        [2*W-1:0] prod_comb;
  logic        [1:0]     unused_prod_top;

  // Sign-extend to the full product width so the multiply is exact.
  always_comb begin
    a_wide    = {{(W + 1){s1_a[W]}}, s1_a};
    b_wide    = {{(W + 1){s1_b[W]}}, s1_b};
    prod_full = a_wide * b_wide;
  end

  // The two guard bits above 2W are never selected by any op.
  assign prod_comb       = prod_full[2*W-1:0];
  assign unused_prod_top = prod_full[2*W+1:2*W];

  if (LATENCY == 1) begin : g_comb_out
    assign out_valid = s1_valid;
    assign prod      = prod_comb;
    assign side_out  = s1_side;
    assign busy      = s1_valid;
  end else begin : g_prod_regs
    localparam int NP = int'(LATENCY) - 1;

    logic [NP-1:0]         p_valid;
    logic [2*W-1:0]        p_prod [NP];
    logic [SIDE_WIDTH-1:0] p_side [NP];

    // Product stages: shift on advance, hold everything (bubbles too) on stall.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        p_valid <= '0;
        for (int i = 0; i < NP; i++) begin
          p_prod[i] <= '0;
          p_side[i] <= '0;
        end
      end else begin
        if (flush) begin
          p_valid <= '0;
        end else if (advance) begin
          p_valid[0] <= s1_valid;
          for (int i = 1; i < NP; i++) begin
            p_valid[i] <= p_valid[i-1];
          end
        end
        if (advance) begin
          p_prod[0] <= prod_comb;
          p_side[0] <= s1_side;
          for (int i = 1; i < NP; i++) begin
            p_prod[i] <= p_prod[i-1];
            p_side[i] <= p_side[i-1];
          end
        end
      end
    end

    assign out_valid = p_valid[NP-1];
    assign prod      = p_prod[NP-1];
    assign side_out  = p_side[NP-1];
    assign busy      = s1_valid | (|p_valid);
  end

endmodule

// File: rtl/mult_unit_pipelined.sv
// Fully pipelined RV32M/RV64M multiply unit (MUL/MULH/MULHSU/MULHU), one op per
// cycle, in-order results with a caller tag, global stall and flush.
// Optional build macro MULT_PERF_CNT_EN adds accepted-op and stall-cycle counters.
module mult_unit_pipelined
  import riscv_config_pkg::*;
  import riscv_core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN,
  parameter int unsigned LATENCY    = DEFAULT_MULT_LATENCY,
  parameter int unsigned TAG_WIDTH  = MULT_TAG_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2:0]            op_type_i,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [TAG_WIDTH-1:0]  tag_o,
  output logic                  illegal_o,
  output logic                  busy_o
`ifdef MULT_PERF_CNT_EN
  ,
  output logic [31:0]           perf_ops_o,
  output logic [31:0]           perf_stall_o
`endif
);

  localparam int unsigned W          = DATA_WIDTH;
  localparam int unsigned SIDE_WIDTH = TAG_WIDTH + 2;

  mult_op_e              op;
  logic                  req_illegal;
  logic [W:0]            a_ext;
  logic [W:0]            b_ext;
  logic [SIDE_WIDTH-1:0] side_in;
  logic [SIDE_WIDTH-1:0] side_out;
  logic                  stall;
  logic                  accept;
  logic                  pipe_valid;
  logic [2*W-1:0]        pipe_prod;
  logic                  pipe_high;
  logic                  pipe_illegal;
  logic [TAG_WIDTH-1:0]  pipe_tag;

  assign op          = mult_op_e'(op_type_i[1:0]);
  assign req_illegal = op_type_i[2];

  // Operand extension and metadata packing for the request being offered.
  always_comb begin
    a_ext   = {op_a_signed(op) & operand_a_i[W-1], operand_a_i};
    b_ext   = {op_b_signed(op) & operand_b_i[W-1], operand_b_i};
    side_in = {op_high_half(op), req_illegal, tag_i};
  end

  // Handshake: the whole pipe freezes while the head result waits for the consumer.
  always_comb begin
    stall      = pipe_valid && !out_ready_i;
    in_ready_o = rst_ni && !stall;
    accept     = in_valid_i && in_ready_o;
  end

  mult_pipe_core #(
    .W          (W),
    .LATENCY    (LATENCY),
    .SIDE_WIDTH (SIDE_WIDTH)
  ) u_core (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush     (flush_i),
    .advance   (!stall),
    .in_valid  (accept),
    .a         (a_ext),
    .b         (b_ext),
    .side_in   (side_in),
    .out_valid (pipe_valid),
    .prod      (pipe_prod),
    .side_out  (side_out),
    .busy      (busy_o)
  );

  assign {pipe_high, pipe_illegal, pipe_tag} = side_out;

  // Result selection; outputs are forced to zero whenever no result is presented.
  always_comb begin
    out_valid_o = pipe_valid;
    result_o    = '0;
    tag_o       = '0;
    illegal_o   = 1'b0;
    if (pipe_valid) begin
      tag_o     = pipe_tag;
      illegal_o = pipe_illegal;
      if (!pipe_illegal) begin
        result_o = pipe_high ? pipe_prod[2*W-1:W] : pipe_prod[W-1:0];
      end
    end
  end

`ifdef MULT_PERF_CNT_EN
  // Free-running counters of handshakes and stalled cycles; flush does not touch them.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_ops_o   <= '0;
      perf_stall_o <= '0;
    end else begin
      if (accept) begin
        perf_ops_o <= perf_ops_o + 32'd1;
      end
      if (stall) begin
        perf_stall_o <= perf_stall_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mult_unit_pipelined.sv
// Scoreboard bench for mult_unit_pipelined: directed cases plus randomized traffic
// checked against a plain-arithmetic reference model.
module tb_mult_unit_pipelined;

  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int TW  = 4;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          flush     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b1;
  logic [2:0]    op_type   = 3'd0;
  logic [DW-1:0] a         = '0;
  logic [DW-1:0] b         = '0;
  logic [TW-1:0] tag       = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] result;
  logic [TW-1:0] tag_out;
  logic          illegal;
  logic          busy;
`ifdef MULT_PERF_CNT_EN
  logic [31:0]   perf_ops;
  logic [31:0]   perf_stall;
`endif

  mult_unit_pipelined #(
    .DATA_WIDTH (DW),
    .LATENCY    (LAT),
    .TAG_WIDTH  (TW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_type_i   (op_type),
    .operand_a_i (a),
    .operand_b_i (b),
    .tag_i       (tag),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .tag_o       (tag_out),
    .illegal_o   (illegal),
    .busy_o      (busy)
`ifdef MULT_PERF_CNT_EN
    ,
    .perf_ops_o  (perf_ops),
    .perf_stall_o(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] res;
    logic [TW-1:0] tg;
    logic          ill;
  } exp_t;

  exp_t          q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] cur_exp  = '0;
  logic          acc_seen = 1'b0;
  longint        m_ops    = 0;
  longint        m_stalls = 0;

  // Reference: exact 64-bit arithmetic on the operands as the ISA defines them.
  function automatic logic [DW-1:0] ref_mul(logic [2:0] op, logic [DW-1:0] x, logic [DW-1:0] y);
    longint          sx = longint'($signed(x));
    longint          sy = longint'($signed(y));
    longint unsigned ux = {32'd0, x};
    longint unsigned uy = {32'd0, y};
    logic [63:0]     p;
    case (op)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'(uy); return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      default: return '0;
    endcase
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  // Monitor: compare the presented result with the scoreboard head; pop on handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got tag %0d result %h, want no output", tag_out, result);
      end else begin
        chk("result", {27'd0, illegal, tag_out, result}, {27'd0, q[0].ill, q[0].tg, q[0].res});
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  // Driver-side bookkeeping just after negedge: what the coming edge will do.
  task automatic half();
    @(negedge clk);
    #1;
    acc_seen = in_valid && in_ready;
    if (!rst_n) begin
      m_ops    = 0;
      m_stalls = 0;
    end else begin
      if (acc_seen) m_ops++;
      if (out_valid && !out_ready) m_stalls++;
    end
    if (!rst_n || flush) q.delete();
    else if (acc_seen) q.push_back('{res: cur_exp, tg: tag, ill: op_type[2]});
  endtask

  task automatic rise();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    half();
    rise();
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  // Offer one op and hold it until handshaken (bounded).
  task automatic issue(logic [2:0] op, logic [DW-1:0] x, logic [DW-1:0] y, logic [TW-1:0] t,
                       logic [DW-1:0] e);
    in_valid = 1'b1;
    op_type  = op;
    a        = x;
    b        = y;
    tag      = t;
    cur_exp  = e;
    for (int w = 0; w < 50; w++) begin
      half();
      rise();
      if (acc_seen) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL issue_timeout: got in_ready low for 50 cycles, want acceptance (tag %0d)", t);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by time limit, want completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] ra, rb;
    logic [2:0]    rop;

    // Reset state
    half();
    rise();
    half();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_tag", tag_out, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    rise();
    rst_n = 1'b1;
    idle(2);

    // 1: MUL 7 * -3, latency exactly LAT
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 4'd5, 32'hFFFF_FFEB);
    in_valid = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      half();
      chk("latency_valid", out_valid, (k == LAT) ? 1 : 0);
      rise();
    end
    idle(2);

    // 2: back-to-back high-half ops, results on consecutive cycles
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 4'd1, 32'h4000_0000);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 32'hFFFF_FFFE);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 32'hFFFF_FFFF);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      half();
      chk("b2b_valid", out_valid, 1);
      rise();
    end
    idle(3);

    // 3: stall with four ops
    issue(3'd0, 32'd11, 32'd12, 4'd4, 32'd132);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 4'd5, 32'hFFFF_FFFF);
    issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 4'd6, ref_mul(3'd3, 32'h1234_5678, 32'h9ABC_DEF0));
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op_type   = 3'd0;
    a         = 32'd100;
    b         = 32'hFFFF_FFFF;
    tag       = 4'd7;
    cur_exp   = 32'hFFFF_FF9C;
    for (int k = 0; k < 5; k++) begin
      half();
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      rise();
    end
    out_ready = 1'b1;
    issue(3'd0, 32'd100, 32'hFFFF_FFFF, 4'd7, 32'hFFFF_FF9C);
    idle(LAT + 4);

    // 4: flush with three in flight and a new request in the same cycle
    issue(3'd0, 32'd2, 32'd3, 4'd8, 32'd6);
    issue(3'd0, 32'd4, 32'd5, 4'd9, 32'd20);
    issue(3'd0, 32'd6, 32'd7, 4'd10, 32'd42);
    op_type = 3'd0;
    a       = 32'd8;
    b       = 32'd9;
    tag     = 4'd11;
    cur_exp = 32'd72;
    flush   = 1'b1;
    half();
    rise();
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      half();
      chk("flush_out_valid", out_valid, 0);
      if (k == 1) chk("flush_busy", busy, 0);
      rise();
    end

    // 5: illegal op then legal MUL on the same operands
    issue(3'd4, 32'd5, 32'd6, 4'd12, 32'd0);
    issue(3'd0, 32'd5, 32'd6, 4'd13, 32'd30);
    idle(LAT + 2);

    // 6: reset mid-stream with two ops in flight
    issue(3'd0, 32'd9, 32'd9, 4'd14, 32'd81);
    issue(3'd1, 32'd9, 32'd9, 4'd15, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    half();
    rise();
    half();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_tag", tag_out, 0);
    chk("mid_rst_illegal", illegal, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
`ifdef MULT_PERF_CNT_EN
    chk("mid_rst_perf_ops", perf_ops, 0);
    chk("mid_rst_perf_stall", perf_stall, 0);
`endif
    rise();
    rst_n = 1'b1;
    idle(2);

    // Randomized traffic with random backpressure and rare flushes
    for (int i = 0; i < 400; i++) begin
      rop = (($urandom % 8) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom % 4);
      case ($urandom % 6)
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom % 6)
        0:       rb = 32'h8000_0000;
        1:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      in_valid  = ($urandom % 10) < 7;
      op_type   = rop;
      a         = ra;
      b         = rb;
      tag       = 4'($urandom);
      cur_exp   = ref_mul(rop, ra, rb);
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 50) == 0;
      step();
    end
    flush     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int w = 0; w < 20 && q.size() != 0; w++) step();
    chk("drain_empty", q.size(), 0);
    half();
    chk("end_busy", busy, 0);
`ifdef MULT_PERF_CNT_EN
    chk("perf_ops", perf_ops, m_ops);
    chk("perf_stall", perf_stall, m_stalls);
`endif
    rise();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_unit_pipelined.md
Name: mult_unit_pipelined

Overview:
Fully pipelined RV32M/RV64M multiply unit for the execute stage. It accepts one MUL/MULH/MULHSU/MULHU operation per cycle over a valid/ready handshake and keeps up to LATENCY operations in flight. Results return in order with a caller-supplied tag. The pipeline supports global backpressure stall and a pipeline flush for branch mispredicts and traps. It replaces the single-operation start/done multiplier.

Parameters:
DATA_WIDTH, XLEN, operand/result width (32 or 64).
LATENCY, DEFAULT_MULT_LATENCY, cycles from input handshake to out_valid_o; legal range 1..8.
TAG_WIDTH, 4, width of the opaque tag carried with each operation (ROB/dest id).

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
flush_i  in  1  kill all in-flight operations
in_valid_i  in  1  operation request valid
in_ready_o  out  1  unit can accept an operation this cycle
op_type_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
operand_a_i  in  DATA_WIDTH  rs1 value
operand_b_i  in  DATA_WIDTH  rs2 value
tag_i  in  TAG_WIDTH  request tag
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
result_o  out  DATA_WIDTH  selected product half
tag_o  out  TAG_WIDTH  tag of the result
illegal_o  out  1  qualifies out_valid_o: op_type was 1xx
busy_o  out  1  any stage holds a valid operation

Behaviour:
- Reset is synchronous and active-low on rst_ni, clocked by clk_i. While rst_ni=0 at a clk_i edge, all stage valid bits clear.
- Output reset values: out_valid_o=0, result_o=0, tag_o=0, illegal_o=0, busy_o=0. in_ready_o=0 while rst_ni=0.
- Operation acceptance: an operation is accepted when in_valid_i && in_ready_o at a rising edge.
- Stall: stall = out_valid_o && !out_ready_i. in_ready_o = rst_ni && !stall, combinational. A stall freezes all stages, including bubbles (no bubble collapse).
- Latency: an operation accepted at edge N presents out_valid_o in the cycle after edge N+LATENCY-1, absent stalls. For LATENCY=1, the product is combinational from the stage-1 registers.
- Throughput: 1 op/cycle sustained. Results are in order; tag and op_type travel with data.
- Arithmetic:
  - Operands are extended to DATA_WIDTH+1 bits: a is sign-extended for MUL/MULH/MULHSU and zero-extended for MULHU; b is sign-extended for MUL/MULH and zero-extended for MULHSU/MULHU.
  - One signed (DATA_WIDTH+1)x(DATA_WIDTH+1) multiply produces p. MUL selects p[DATA_WIDTH-1:0]; the others select p[2*DATA_WIDTH-1:DATA_WIDTH].
  - Product registers are placed after the multiplier so synthesis can retime them across it.
- Illegal op (op_type_i[2]=1): the operation is accepted and flows through the pipeline normally, returning result_o=0 and illegal_o=1. No exception is raised here.
- flush_i:
  - Clears every valid bit at the edge, including one in the output stage under stall.
  - An operation handshaken in the same cycle as flush_i is dropped.
  - out_valid_o=0 in the following cycle.
  - flush_i has priority over stall.
- result_o and tag_o hold their value while out_valid_o=1 && !out_ready_i. They are don't-care when out_valid_o=0 (reset value 0).
- busy_o = OR of all stage valid bits.

Optional Feature:
MULT_PERF_CNT_EN
- Defined: adds outputs perf_ops_o[31:0] and perf_stall_o[31:0].
  - perf_ops_o counts accepted operations.
  - perf_stall_o counts cycles with stall=1.
  - Both are synchronously reset to 0 and wrap at 2^32.
  - Both are unaffected by flush_i.
- Undefined: neither the ports nor the counters exist.

Decomposition:
- riscv_core_pkg: mult_op_e enum (MUL/MULH/MULHSU/MULHU), MULT_TAG_WIDTH, and a mult_req_t struct (op, a, b, tag).
- riscv_config_pkg: DEFAULT_MULT_LATENCY.
- Sub-module mult_pipe_core: signed (W+1)x(W+1) multiplier plus a LATENCY-deep valid/data shift pipeline with a stall enable and a flush input.
- The top level handles operand extension, result selection, the handshake and the counters.

Test Plan:
1. MUL a=7, b=0xFFFFFFFD (W=32) -> result_o=0xFFFFFFEB, after exactly LATENCY cycles, tag_o equal to the request tag.
2. Back-to-back MULH 0x80000000*0x80000000, MULHU 0xFFFFFFFF*0xFFFFFFFF, MULHSU 0xFFFFFFFF*0xFFFFFFFF on consecutive cycles -> 0x40000000, 0xFFFFFFFE, 0xFFFFFFFF on consecutive cycles, tags 1,2,3 in order.
3. Issue 4 ops with LATENCY=3 and hold out_ready_i=0 for 5 cycles -> in_ready_o=0 while stalled, first result held stable, no loss or duplication. After release, all 4 results drain in order.
4. With 3 ops in flight, pulse flush_i together with a new valid request -> out_valid_o=0 for the next LATENCY cycles, busy_o=0 next cycle, and the flushed tags never appear.
5. op_type=3'b100, a=5, b=6 -> result_o=0, illegal_o=1. A following MUL 5*6 returns 30 with illegal_o=0.
6. Drive rst_ni=0 for one edge mid-stream with 2 ops in flight -> all outputs at reset values next cycle, busy_o=0, and (if MULT_PERF_CNT_EN) both counters at 0.
